// File: rtl/seg7_scan_ctrl.sv
// Multiplexed 7-segment scan controller: frame-latched hex data, divided digit walk,
// dead-time per slot and optional leading-zero blanking. All outputs are registered.
module seg7_scan_ctrl #(
  parameter int DIGITS         = 8,
  parameter int DIV            = 50000,
  parameter int GAP            = 2,
  parameter int SEL_ACTIVE_LOW = 1
) (
  input  logic                  iCLK,
  input  logic                  iRST,
  input  logic                  iEN,
  input  logic [4*DIGITS-1:0]   iDATA,
  input  logic [DIGITS-1:0]     iDP,
  input  logic                  iLZB,
  output logic [3:0]            oDIG,
  output logic                  oDP,
  output logic [DIGITS-1:0]     oSEL,
  output logic                  oFRAME
);

  localparam int CW = (DIV > 2) ? $clog2(DIV) : 1;
  localparam int IW = $clog2(DIGITS);
  localparam logic [CW-1:0]     CNT_LAST = CW'(DIV - 1);
  localparam logic [CW-1:0]     CNT_GAP  = CW'(GAP);
  localparam logic [IW-1:0]     IDX_LAST = IW'(DIGITS - 1);
  localparam logic [DIGITS-1:0] SEL_OFF  = (SEL_ACTIVE_LOW != 0) ? {DIGITS{1'b1}} : {DIGITS{1'b0}};

  logic [CW-1:0]       cnt_q, cnt_d;
  logic [IW-1:0]       idx_q, idx_d;
  logic [4*DIGITS-1:0] shadow_q, shadow_d;
  logic [DIGITS-1:0]   dp_shadow_q, dp_shadow_d;
  logic                load_pend_q, load_pend_d;
  logic [3:0]          dig_q, dig_d;
  logic                dp_q, dp_d;
  logic [DIGITS-1:0]   sel_q, sel_d;
  logic                frame_q, frame_d;

  logic                tick;
  logic                wrap;
  logic [3:0]          nib [DIGITS];
  logic [DIGITS-1:0]   zero_from;
  logic                all_zero;
  logic                blank;
  logic                on;
  logic [DIGITS-1:0]   sel_oh;

  always_comb begin
    tick        = (cnt_q == CNT_LAST);
    wrap        = tick && (idx_q == IDX_LAST);
    cnt_d       = tick ? '0 : cnt_q + 1'b1;
    idx_d       = idx_q;
    if (tick) begin
      idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
    end
    load_pend_d = 1'b0;
    shadow_d    = shadow_q;
    dp_shadow_d = dp_shadow_q;
    // Latch the next frame's content only at the frame boundary so a digit never tears.
    if (wrap || load_pend_q) begin
      shadow_d    = iDATA;
      dp_shadow_d = iDP;
    end
    frame_d = wrap;

    for (int i = 0; i < DIGITS; i++) begin
      nib[i] = shadow_q[4*i +: 4];
    end
    // zero_from[i]: every nibble from i up to the most significant digit is zero.
    all_zero = 1'b1;
    for (int i = DIGITS - 1; i >= 0; i--) begin
      all_zero     = all_zero && (nib[i] == 4'h0);
      zero_from[i] = all_zero;
    end
    blank = iLZB && (idx_q != '0) && zero_from[idx_q];
    on    = iEN && (cnt_q >= CNT_GAP) && !blank;

    dig_d         = nib[idx_q];
    dp_d          = dp_shadow_q[idx_q] && on;
    sel_oh        = '0;
    sel_oh[idx_q] = on;
    sel_d         = (SEL_ACTIVE_LOW != 0) ? ~sel_oh : sel_oh;
  end

  always_ff @(posedge iCLK or posedge iRST) begin
    if (iRST) begin
      cnt_q       <= '0;
      idx_q       <= '0;
      shadow_q    <= '0;
      dp_shadow_q <= '0;
      load_pend_q <= 1'b1;
      dig_q       <= '0;
      dp_q        <= 1'b0;
      sel_q       <= SEL_OFF;
      frame_q     <= 1'b0;
    end else begin
      cnt_q       <= cnt_d;
      idx_q       <= idx_d;
      shadow_q    <= shadow_d;
      dp_shadow_q <= dp_shadow_d;
      load_pend_q <= load_pend_d;
      dig_q       <= dig_d;
      dp_q        <= dp_d;
      sel_q       <= sel_d;
      frame_q     <= frame_d;
    end
  end

  assign oDIG   = dig_q;
  assign oDP    = dp_q;
  assign oSEL   = sel_q;
  assign oFRAME = frame_q;

endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// Bench for seg7_scan_ctrl: directed scenarios then random inputs, checked against
// a cycle-count based reference of the scan rules.
module tb_seg7_scan_ctrl;

  localparam int DIGITS = 4;
  localparam int DIV    = 4;
  localparam int GAP    = 1;
  localparam int FRAME  = DIGITS * DIV;

  logic        clk = 1'b0;
  logic        iRST;
  logic        iEN;
  logic [15:0] iDATA;
  logic [3:0]  iDP;
  logic        iLZB;
  logic [3:0]  oDIG;
  logic        oDP;
  logic [3:0]  oSEL;
  logic        oFRAME;

  int          vectors     = 0;
  int          miscompares = 0;
  int          n_frame     = 0;
  int          n_sel       = 0;
  int          n_sel0      = 0;
  int unsigned c           = 0;
  logic [15:0] m_shadow    = '0;
  logic [3:0]  m_dp        = '0;

  seg7_scan_ctrl #(
    .DIGITS(DIGITS), .DIV(DIV), .GAP(GAP), .SEL_ACTIVE_LOW(1)
  ) dut (
    .iCLK(clk), .iRST(iRST), .iEN(iEN), .iDATA(iDATA), .iDP(iDP), .iLZB(iLZB),
    .oDIG(oDIG), .oDP(oDP), .oSEL(oSEL), .oFRAME(oFRAME)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    assert (obs === exp)
    else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h (cycle %0d)", tag, obs, exp, c);
    end
  endtask

  task automatic model_reset();
    c        = 0;
    m_shadow = '0;
    m_dp     = '0;
  endtask

  // One clock: derive the expected outputs from time since reset and the latched frame.
  task automatic step();
    int unsigned pos, slot;
    logic [15:0] nibs;
    logic        blank, on, e_dp, e_frame;
    logic [3:0]  e_sel, e_dig;
    @(posedge clk);
    pos     = c % DIV;
    slot    = (c / DIV) % DIGITS;
    nibs    = m_shadow >> (4 * slot);
    e_dig   = nibs[3:0];
    blank   = iLZB && (slot != 0) && (nibs == 16'h0);
    on      = iEN && (pos >= GAP) && !blank;
    e_sel   = 4'hF;
    if (on) e_sel[slot] = 1'b0;
    e_dp    = on && m_dp[slot];
    e_frame = (pos == DIV - 1) && (slot == DIGITS - 1);
    if (c == 0 || e_frame) begin
      m_shadow = iDATA;
      m_dp     = iDP;
    end
    c++;
    #1;
    vectors++;
    chk("sel", oSEL, e_sel);
    chk("dig", oDIG, e_dig);
    chk("dp", oDP, e_dp);
    chk("frame", oFRAME, e_frame);
    chk("onehot", $countones(~oSEL) <= 1, 1);
    if (oFRAME) n_frame++;
    if (oSEL != 4'hF) n_sel++;
    if (oSEL == 4'hE) n_sel0++;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  initial begin
    int f0, s0, z0;
    iRST  = 1'b1;
    iEN   = 1'b1;
    iDATA = 16'h1234;
    iDP   = 4'h0;
    iLZB  = 1'b0;
    repeat (3) @(negedge clk);
    vectors++;
    chk("rst_sel", oSEL, 4'hF);
    chk("rst_dig", oDIG, 4'h0);
    chk("rst_dp", oDP, 1'b0);
    chk("rst_frame", oFRAME, 1'b0);

    // Basic scan of 1234
    iRST = 1'b0;
    model_reset();
    step();
    step();
    chk("first_sel", oSEL, 4'hE);
    chk("first_dig", oDIG, 4'h4);
    f0 = n_frame;
    run(32);
    chk("frame_cnt32", n_frame - f0, 2);

    // Data change in the middle of digit 1's slot
    while ((c % FRAME) != DIV + 2) step();
    iDATA = 16'hABCD;
    run(2 * FRAME);

    // Leading-zero blanking on 0050
    iLZB  = 1'b1;
    iDATA = 16'h0050;
    run(2 * FRAME);

    // All-zero data: only digit 0 ever lights
    iDATA = 16'h0000;
    run(FRAME);
    s0 = n_sel;
    z0 = n_sel0;
    run(2 * FRAME);
    chk("zero_sel_cnt", n_sel - s0, 2 * (DIV - GAP));
    chk("zero_sel0_cnt", n_sel0 - z0, 2 * (DIV - GAP));

    // Decimal point on digit 2
    iLZB  = 1'b0;
    iDATA = 16'h1234;
    iDP   = 4'b0100;
    run(2 * FRAME);

    // Display disabled for a frame, then re-enabled
    iEN = 1'b0;
    s0  = n_sel;
    f0  = n_frame;
    run(FRAME);
    chk("dis_sel_cnt", n_sel - s0, 0);
    chk("dis_frame_cnt", n_frame - f0, 1);
    iEN = 1'b1;
    run(FRAME + 5);

    // Asynchronous reset in the middle of an active slot
    #3;
    iRST = 1'b1;
    #1;
    vectors++;
    chk("arst_sel", oSEL, 4'hF);
    chk("arst_dig", oDIG, 4'h0);
    chk("arst_dp", oDP, 1'b0);
    chk("arst_frame", oFRAME, 1'b0);
    iDATA = 16'h9876;
    iDP   = 4'b0001;
    repeat (2) @(negedge clk);
    iRST = 1'b0;
    model_reset();
    run(2);
    chk("arst_first_sel", oSEL, 4'hE);
    chk("arst_first_dig", oDIG, 4'h6);
    chk("arst_first_dp", oDP, 1'b1);
    run(FRAME);

    // Random inputs
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 6) == 0) begin
        iDATA = 16'($urandom) & 16'($urandom);
        if ($urandom_range(0, 1) == 1) iDATA = iDATA & 16'h00FF;
      end
      if ($urandom_range(0, 9) == 0) iDP = 4'($urandom);
      if ($urandom_range(0, 19) == 0) iLZB = ~iLZB;
      iEN = ($urandom_range(0, 9) != 0);
      step();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
